ram_portb_ctrl: RTL and testbench

Request queue and retry controller that sits directly upstream of the dual-port RAM's Port B. It accepts read/write requests from a Port B client over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on the RAM's Port B, retries any request the RAM rejects with busy_B because Port A has priority, and returns one response per request.

---
 rtl/ram_portb_ctrl_if.sv | 36 +++
 rtl/ram_portb_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_portb_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_portb_ctrl_if.sv
// Port B client + RAM-side bundle for ram_portb_ctrl; slave = the controller, master = client/RAM side.
interface ram_portb_ctrl_if #(
    parameter int DEPTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [9:0]             req_addr;
    logic [7:0]             req_wdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_we;
    logic [7:0]             rsp_rdata;
    logic                   rsp_err;

    logic [$clog2(DEPTH):0] fifo_level;

    logic                   ram_we_B;
    logic [9:0]             ram_addr_B;
    logic [7:0]             ram_din_B;
    logic [7:0]             ram_dout_B;
    logic                   ram_busy_B;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout_B, ram_busy_B,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, fifo_level,
               ram_we_B, ram_addr_B, ram_din_B
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout_B, ram_busy_B,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, fifo_level,
               ram_we_B, ram_addr_B, ram_din_B
    );
endinterface

// File: rtl/ram_portb_ctrl.sv
// Queues Port B requests, issues one at a time (4 cycles uncontended, +2 per busy_B retry), req_ready = !full.
// Define RAM_PORTB_RETRY_LIMIT_EN to bound retries at MAX_RETRY and answer with rsp_err instead.
module ram_portb_ctrl #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 15
) (
    input  logic            clk,
    input  logic            rst,
    ram_portb_ctrl_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_RETRY < 1 || MAX_RETRY > 255) begin : g_bad_params
        $error("ram_portb_ctrl: DEPTH must be a power of 2 >= 2, MAX_RETRY in 1..255");
    end

    logic [18:0] fifo_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] level;
    logic        push, pop, empty, full;
    logic [18:0] head;

    logic [1:0]  state_q, state_d;
    logic        op_we_q, op_we_d;
    logic [9:0]  op_addr_q, op_addr_d;
    logic [7:0]  op_wdata_q, op_wdata_d;
    logic [7:0]  rdata_q, rdata_d;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
    localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);
    logic [7:0]  retry_q, retry_d;
    logic        err_q, err_d;
`endif

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign push  = bus.req_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {bus.req_we, bus.req_addr, bus.req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_we_d    = op_we_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        rdata_d    = rdata_q;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
        retry_d    = retry_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {op_we_d, op_addr_d, op_wdata_d} = head;
                    rdata_d = 8'h00;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
                    retry_d = 8'h00;
                    err_d   = 1'b0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                // busy_B reports on the access made during the preceding ISSUE cycle
                if (!bus.ram_busy_B) begin
                    rdata_d = op_we_q ? 8'h00 : bus.ram_dout_B;
                    state_d = S_RESP;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
                end else if (retry_q == RETRY_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                    state_d = S_RESP;
                end else begin
                    retry_d = retry_q + 8'd1;
                    state_d = S_ISSUE;
`else
                end else begin
                    state_d = S_ISSUE;
`endif
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_we_q    <= 1'b0;
            op_addr_q  <= 10'h000;
            op_wdata_q <= 8'h00;
            rdata_q    <= 8'h00;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
            retry_q    <= 8'h00;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_we_q    <= op_we_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            rdata_q    <= rdata_d;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
            retry_q    <= retry_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.req_ready  = !full;
    assign bus.fifo_level = level;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_we     = op_we_q;
    assign bus.rsp_rdata  = rdata_q;
`ifdef RAM_PORTB_RETRY_LIMIT_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif
    // Address/data stay on the last op so CHECK re-reads the same location harmlessly
    assign bus.ram_we_B   = (state_q == S_ISSUE) && op_we_q;
    assign bus.ram_addr_B = op_addr_q;
    assign bus.ram_din_B  = op_wdata_q;
endmodule

// File: tb/tb_ram_portb_ctrl.sv
// Self-checking bench: dual-port RAM model with Port A priority, in-order response scoreboard.
module tb_ram_portb_ctrl;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 3;
    localparam int WAIT_LIM  = 400;

    typedef struct packed {
        logic       we;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_portb_ctrl_if #(.DEPTH(DEPTH)) bus ();

    ram_portb_ctrl #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Port A traffic generator state and the RAM itself (Port A always wins)
    logic       pa_we   = 1'b0;
    logic [9:0] pa_addr = 10'h000;
    logic [7:0] pa_din  = 8'h00;
    logic [7:0] ram [1024];

    always @(posedge clk) begin
        if (pa_we) ram[pa_addr] <= pa_din;
        else if (bus.ram_we_B) ram[bus.ram_addr_B] <= bus.ram_din_B;
        bus.ram_busy_B <= pa_we;
        bus.ram_dout_B <= ram[bus.ram_addr_B];
    end

    int   cyc = 0;
    int   we_cnt = 0;
    rsp_t rsp_q[$];
    int   rsp_cyc_q[$];
    int   acc_cyc_q[$];
    rsp_t exp_q[$];
    logic [7:0] ref_mem [1024];
    bit   rnd_on = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) acc_cyc_q.push_back(cyc);
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_q.push_back({bus.rsp_we, bus.rsp_rdata, bus.rsp_err});
            rsp_cyc_q.push_back(cyc);
        end
        if (bus.ram_we_B) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_on) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            pa_we         = ($urandom_range(0, 2) == 0);
            pa_addr       = {2'b10, 8'($urandom)};
            pa_din        = 8'($urandom);
        end
    endtask

    // mode 0: scoreboard from ref_mem, 1: expect retry-limit error, 2: untracked
    task automatic send(input logic we, input logic [9:0] a, input logic [7:0] d, input int mode);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < WAIT_LIM) begin
            tick();
            n++;
        end
        chk("req_ready_wait_expired", 32'(n >= WAIT_LIM), 32'd0);
        if (mode == 0) begin
            if (we) begin
                ref_mem[a] = d;
                exp_q.push_back({1'b1, 8'h00, 1'b0});
            end else begin
                exp_q.push_back({1'b0, ref_mem[a], 1'b0});
            end
        end else if (mode == 1) begin
            exp_q.push_back({we, 8'h00, 1'b1});
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int lim);
        int n = 0;
        while (rsp_q.size() < target && n < lim) begin
            tick();
            n++;
        end
        chk("rsp_wait_count", 32'(rsp_q.size() >= target), 32'd1);
    endtask

    task automatic check_rsps(input string tag, input int rb, input int eb);
        int ne = exp_q.size() - eb;
        chk({tag, "_rsp_count"}, 32'(rsp_q.size() - rb), 32'(ne));
        for (int i = 0; i < ne && rb + i < rsp_q.size(); i++) begin
            chk({tag, "_rsp_we"},    32'(rsp_q[rb+i].we),    32'(exp_q[eb+i].we));
            chk({tag, "_rsp_rdata"}, 32'(rsp_q[rb+i].rdata), 32'(exp_q[eb+i].rdata));
            chk({tag, "_rsp_err"},   32'(rsp_q[rb+i].err),   32'(exp_q[eb+i].err));
        end
    endtask

    task automatic check_lat(input string tag, input int ai, input int ri, input int lat);
        if (ai < acc_cyc_q.size() && ri < rsp_cyc_q.size())
            chk(tag, 32'(rsp_cyc_q[ri] - acc_cyc_q[ai]), 32'(lat));
        else
            chk({tag, "_missing"}, 32'(rsp_cyc_q.size()), 32'(ri + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, eb, ab, w0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h000;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

        // Zero the low RAM through Port A while the controller is held in reset
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pa_we   = 1'b1;
            pa_addr = 10'(i);
            pa_din  = 8'h00;
            tick();
        end
        pa_we = 1'b0;
        chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rst_rsp_we",     32'(bus.rsp_we),     32'd0);
        chk("rst_rsp_rdata",  32'(bus.rsp_rdata),  32'd0);
        chk("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
        chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_ram_we_B",   32'(bus.ram_we_B),   32'd0);
        chk("rst_ram_addr_B", 32'(bus.ram_addr_B), 32'd0);
        chk("rst_ram_din_B",  32'(bus.ram_din_B),  32'd0);
        rst = 1'b0;
        tick();

        // Uncontended write then read-back
        rb = rsp_q.size(); eb = exp_q.size(); ab = acc_cyc_q.size(); w0 = we_cnt;
        send(1'b1, 10'h010, 8'hA5, 0);
        wait_rsp(rb + 1, WAIT_LIM);
        send(1'b0, 10'h010, 8'h00, 0);
        wait_rsp(rb + 2, WAIT_LIM);
        chk("wr_we_B_cycles", 32'(we_cnt - w0), 32'd1);
        check_lat("wr_latency", ab, rb, 4);
        check_lat("rd_latency", ab + 1, rb + 1, 4);
        check_rsps("basic", rb, eb);

        // Port A hammers the same address for 6 cycles: two rejected ISSUEs
        rb = rsp_q.size(); eb = exp_q.size(); ab = acc_cyc_q.size();
        ref_mem[10'h010] = 8'h36;
        pa_we = 1'b1; pa_addr = 10'h010; pa_din = 8'h31;
        send(1'b0, 10'h010, 8'h00, 0);
        for (int i = 1; i < 6; i++) begin
            pa_din = 8'(8'h31 + i);
            tick();
        end
        pa_we = 1'b0;
        wait_rsp(rb + 1, WAIT_LIM);
        for (int i = 0; i < 20; i++) tick();
        check_lat("contend_latency", ab, rb, 8);
        chk("contend_no_dup", 32'(rsp_q.size() - rb), 32'd1);
        check_rsps("contend", rb, eb);

`ifdef RAM_PORTB_RETRY_LIMIT_EN
        // Port A never lets go: MAX_RETRY attempts, then an error response
        rb = rsp_q.size(); eb = exp_q.size(); ab = acc_cyc_q.size(); w0 = we_cnt;
        pa_we = 1'b1; pa_addr = 10'h020; pa_din = 8'h77;
        ref_mem[10'h020] = 8'h77;
        send(1'b1, 10'h020, 8'h11, 1);
        wait_rsp(rb + 1, WAIT_LIM);
        pa_we = 1'b0;
        chk("limit_issue_cycles", 32'(we_cnt - w0), 32'(MAX_RETRY));
        check_lat("limit_latency", ab, rb, 4 + 2 * (MAX_RETRY - 1));
        send(1'b0, 10'h020, 8'h00, 0);
        wait_rsp(rb + 2, WAIT_LIM);
        check_rsps("limit", rb, eb);
`endif

        // Backpressure: one in flight plus DEPTH queued fills the block
        rb = rsp_q.size(); eb = exp_q.size();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'(i % 2), 10'(10'h030 + i), 8'(8'hC0 + i), 0);
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_fifo_level", 32'(bus.fifo_level), 32'(DEPTH));
        for (int i = 0; i < 3; i++) tick();
        bus.rsp_ready = 1'b1;
        wait_rsp(rb + 5, WAIT_LIM);
        for (int i = 1; i < 5; i++)
            if (rb + i < rsp_cyc_q.size())
                chk("bp_throughput", 32'(rsp_cyc_q[rb+i] - rsp_cyc_q[rb+i-1]), 32'd4);
        check_rsps("bp", rb, eb);

        // Reset while an op sits in CHECK with three more queued
        rb = rsp_q.size();
        pa_we = 1'b1; pa_addr = 10'h2FF; pa_din = 8'h00;
        for (int i = 0; i < 4; i++) send(1'b0, 10'(10'h040 + i), 8'h00, 2);
        tick();
        chk("pre_rst_fifo_level", 32'(bus.fifo_level), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        chk("mid_rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("mid_rst_req_ready",  32'(bus.req_ready),  32'd1);
        chk("mid_rst_ram_we_B",   32'(bus.ram_we_B),   32'd0);
        pa_we = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("mid_rst_no_rsp", 32'(rsp_q.size() - rb), 32'd0);

        // Random traffic: random Port A contention, random response backpressure
        rb = rsp_q.size(); eb = exp_q.size();
        rnd_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom), 0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_on = 1'b0;
        pa_we = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_rsp(rb + 60, 4000);
        check_rsps("rand", rb, eb);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
